// File: rtl/mkio_manchester_rx.sv
// Manchester-II receive decoder for one MKIO (1553B) channel.
// Recovers sync type, 16 data bits and odd parity; reports each word as a one-cycle strobe.
`timescale 1ns/1ps
module mkio_manchester_rx #(
  parameter int unsigned CLK_PER_HALFBIT = 16,
  parameter int unsigned SYNC_MIN        = 44,
  parameter int unsigned SYNC_MAX        = 68,
  parameter int unsigned RESYNC_WIN      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        DI1,
  input  logic        DI0,
  output logic [15:0] rx_data,
  output logic        rx_cmd_sync,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  rx_err_code,
  output logic        rx_busy
);

  localparam int unsigned SyncLen = 3 * CLK_PER_HALFBIT;
  localparam int unsigned CntW    = $clog2(SyncLen);
  localparam int unsigned RunW    = $clog2(SYNC_MAX + 2);

  localparam logic [CntW-1:0] CntH1      = CntW'(CLK_PER_HALFBIT / 2);
  localparam logic [CntW-1:0] CntH2      = CntW'(CLK_PER_HALFBIT + CLK_PER_HALFBIT / 2);
  localparam logic [CntW-1:0] CntMid     = CntW'(CLK_PER_HALFBIT);
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(2 * CLK_PER_HALFBIT - 1);
  localparam logic [CntW-1:0] CntSyncEnd = CntW'(SyncLen - 1);
  localparam logic [CntW-1:0] CntWinLo   = CntW'(CLK_PER_HALFBIT - RESYNC_WIN);
  localparam logic [CntW-1:0] CntWinHi   = CntW'(CLK_PER_HALFBIT + RESYNC_WIN);
  localparam logic [RunW-1:0] RunMin     = RunW'(SYNC_MIN);
  localparam logic [RunW-1:0] RunMax     = RunW'(SYNC_MAX);
  localparam logic [RunW-1:0] RunSat     = RunW'(SYNC_MAX + 1);
  localparam logic [4:0]      LastBit    = 5'd16;
  localparam logic [1:0]      LvPos      = 2'b10;

  localparam logic [1:0] CodeSync = 2'b01;
  localparam logic [1:0] CodeManch = 2'b10;
  localparam logic [1:0] CodePar = 2'b11;

  typedef enum logic [1:0] {StIdle, StSync2, StData} state_e;

  function automatic logic lv_valid(input logic [1:0] lv);
    return lv[1] ^ lv[0];
  endfunction

  // Line level as {DI1, DI0}: s1 is the newest synchronised sample, s2 the working level.
  logic [1:0]      s1_q, s2_q, s3_q;
  logic [RunW-1:0] run_q, run_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [1:0]      h1_q, h1_d;
  logic [1:0]      post_q, post_d;
  logic            cmd_q, cmd_d;
  logic [15:0]     shift_q, shift_d;
  logic [15:0]     data_d;
  logic            cmd_out_d, valid_d, err_d, busy_d;
  logic [1:0]      code_d;
  logic            sync_ok, resync, bit_val;

  always_comb begin
    run_d = '0;
    if (lv_valid(s2_q) && (s1_q == s2_q)) begin
      run_d = (run_q == RunSat) ? run_q : run_q + 1'b1;
    end
  end

  // A sync edge is seen one stage early so that cnt = 0 lines up with the new level in s2.
  assign sync_ok = lv_valid(s1_q) && lv_valid(s2_q) && (s1_q != s2_q) &&
                   (run_q >= RunMin) && (run_q <= RunMax);
  assign resync  = (s2_q != s3_q) && (cnt_q >= CntWinLo) && (cnt_q <= CntWinHi);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    h1_d      = h1_q;
    post_d    = post_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    data_d    = rx_data;
    cmd_out_d = rx_cmd_sync;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    code_d    = '0;
    bit_val   = (h1_q == LvPos);

    unique case (state_q)
      StIdle: begin
        if (sync_ok) begin
          state_d = StSync2;
          cnt_d   = '0;
          bit_d   = '0;
          cmd_d   = (s2_q == LvPos);
          post_d  = s1_q;
        end
      end
      StSync2: begin
        cnt_d = cnt_q + 1'b1;
        if ((cnt_q == CntH2) && (s2_q != post_q)) begin
          state_d = StIdle;
          err_d   = 1'b1;
          code_d  = CodeSync;
        end else if (cnt_q == CntSyncEnd) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StData: begin
        cnt_d = (cnt_q == CntBitEnd) ? '0 : cnt_q + 1'b1;
        if (resync) begin
          cnt_d = CntMid;
        end
        if (cnt_q == CntBitEnd) begin
          bit_d = bit_q + 1'b1;
        end
        if (cnt_q == CntH1) begin
          h1_d = s2_q;
        end
        if (cnt_q == CntH2) begin
          if (!lv_valid(h1_q) || !lv_valid(s2_q) || (h1_q == s2_q)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            code_d  = CodeManch;
          end else if (bit_q == LastBit) begin
            // bit_val is the parity bit here; the word must carry an odd number of ones.
            state_d   = StIdle;
            data_d    = shift_q;
            cmd_out_d = cmd_q;
            if (^{shift_q, bit_val}) begin
              valid_d = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = CodePar;
            end
          end else begin
            shift_d = {shift_q[14:0], bit_val};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!rx_en) begin
      state_d = StIdle;
      valid_d = 1'b0;
      err_d   = 1'b0;
      code_d  = '0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      run_q       <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      h1_q        <= '0;
      post_q      <= '0;
      cmd_q       <= 1'b0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_cmd_sync <= 1'b0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= '0;
      rx_busy     <= 1'b0;
    end else begin
      s1_q        <= {DI1, DI0};
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      run_q       <= run_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      h1_q        <= h1_d;
      post_q      <= post_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      rx_data     <= data_d;
      rx_cmd_sync <= cmd_out_d;
      rx_valid    <= valid_d;
      rx_err      <= err_d;
      rx_err_code <= code_d;
      rx_busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mkio_manchester_rx.sv
// Self-checking bench for mkio_manchester_rx: directed word scenarios plus randomised words
// compared against a word-level outcome model.
`timescale 1ns/1ps
module tb_mkio_manchester_rx;

  localparam logic [1:0] LvPos  = 2'b10;
  localparam logic [1:0] LvNeg  = 2'b01;
  localparam logic [1:0] LvIdle = 2'b00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_en = 1'b0;
  logic        DI1 = 1'b0;
  logic        DI0 = 1'b0;
  logic [15:0] rx_data;
  logic        rx_cmd_sync;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  rx_err_code;
  logic        rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit          is_valid;
    logic [1:0]  code;
    logic [15:0] data;
    logic        cmd;
    logic        busy;
    int          cyc;
  } ev_t;

  ev_t evq[$];

  mkio_manchester_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .DI1         (DI1),
    .DI0         (DI0),
    .rx_data     (rx_data),
    .rx_cmd_sync (rx_cmd_sync),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid || rx_err) begin
      ev_t e;
      check("strobe_exclusive", {31'b0, rx_valid & rx_err}, 32'd0);
      e.is_valid = rx_valid;
      e.code     = rx_err_code;
      e.data     = rx_data;
      e.cmd      = rx_cmd_sync;
      e.busy     = rx_busy;
      e.cyc      = cyc;
      evq.push_back(e);
    end
  end

  // Word-level outcome: odd ones count over data+parity is good, otherwise parity error.
  function automatic ev_t model(input bit cmd, input logic [15:0] data, input bit par);
    ev_t e;
    e.is_valid = ^{data, par};
    e.code     = e.is_valid ? 2'b00 : 2'b11;
    e.data     = data;
    e.cmd      = cmd;
    e.busy     = 1'b0;
    e.cyc      = 0;
    return e;
  endfunction

  task automatic hold(input logic [1:0] lv, input int n);
    {DI1, DI0} = lv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // force_idx >= 0 sends that bit as +1 for both halves.
  task automatic send_word(input bit cmd, input logic [15:0] data, input bit par, input int h,
                           input int nbits, input int force_idx);
    hold(cmd ? LvPos : LvNeg, 3 * h);
    hold(cmd ? LvNeg : LvPos, 3 * h);
    for (int i = 0; i < nbits; i++) begin
      bit b;
      b = (i < 16) ? data[15 - i] : par;
      if (i == force_idx) begin
        hold(LvPos, 2 * h);
      end else begin
        hold(b ? LvPos : LvNeg, h);
        hold(b ? LvNeg : LvPos, h);
      end
    end
  endtask

  task automatic expect_event(input string tag, input ev_t exp, input bit chk_data,
                              output int ev_cyc);
    int waited;
    waited = 0;
    ev_cyc = -1;
    while (evq.size() == 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_seen"}, (evq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (evq.size() != 0) begin
      ev_t e;
      e = evq.pop_front();
      ev_cyc = e.cyc;
      check({tag, "_valid"}, {31'b0, e.is_valid}, {31'b0, exp.is_valid});
      check({tag, "_code"}, {30'b0, e.code}, {30'b0, exp.code});
      check({tag, "_busy"}, {31'b0, e.busy}, 32'd0);
      if (chk_data) begin
        check({tag, "_data"}, {16'b0, e.data}, {16'b0, exp.data});
        check({tag, "_cmd"}, {31'b0, e.cmd}, {31'b0, exp.cmd});
      end
    end
  endtask

  initial begin
    ev_t exp;
    int  c1, c2;

    // Reset state
    hold(LvIdle, 5);
    check("rst_data", {16'b0, rx_data}, 32'd0);
    check("rst_cmd", {31'b0, rx_cmd_sync}, 32'd0);
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_err", {31'b0, rx_err}, 32'd0);
    check("rst_code", {30'b0, rx_err_code}, 32'd0);
    check("rst_busy", {31'b0, rx_busy}, 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    hold(LvIdle, 20);

    // Command word 0x0867, good parity
    fork
      send_word(1'b1, 16'h0867, 1'b1, 16, 17, -1);
      begin
        repeat (300) @(negedge clk);
        check("t1_busy_mid", {31'b0, rx_busy}, 32'd1);
      end
    join
    hold(LvIdle, 60);
    exp = model(1'b1, 16'h0867, 1'b1);
    expect_event("t1", exp, 1'b1, c1);
    check("t1_no_extra", evq.size(), 32'd0);

    // Back-to-back data words
    send_word(1'b0, 16'hA5A5, 1'b1, 16, 17, -1);
    send_word(1'b0, 16'h0001, 1'b0, 16, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b0, 16'hA5A5, 1'b1);
    expect_event("t2a", exp, 1'b1, c1);
    exp = model(1'b0, 16'h0001, 1'b0);
    expect_event("t2b", exp, 1'b1, c2);
    check("t2_spacing", c2 - c1, 32'd640);

    // Parity error
    send_word(1'b1, 16'h0867, 1'b0, 16, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b1, 16'h0867, 1'b0);
    expect_event("t3", exp, 1'b1, c1);

    // Manchester error, then a good word after the line settles
    send_word(1'b0, 16'h1234, 1'b0, 16, 17, 5);
    exp.is_valid = 1'b0;
    exp.code = 2'b10;
    expect_event("t4_err", exp, 1'b0, c1);
    hold(LvIdle, 1500);
    evq.delete();
    send_word(1'b0, 16'h00FF, 1'b1, 16, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b0, 16'h00FF, 1'b1);
    expect_event("t4_next", exp, 1'b1, c1);

    // Reset in the middle of a command word
    send_word(1'b1, 16'h0867, 1'b1, 16, 8, -1);
    reset = 1'b0;
    hold(LvIdle, 3);
    @(negedge clk);
    check("t6_data", {16'b0, rx_data}, 32'd0);
    check("t6_cmd", {31'b0, rx_cmd_sync}, 32'd0);
    check("t6_valid", {31'b0, rx_valid}, 32'd0);
    check("t6_err", {31'b0, rx_err}, 32'd0);
    check("t6_code", {30'b0, rx_err_code}, 32'd0);
    check("t6_busy", {31'b0, rx_busy}, 32'd0);
    #1;
    reset = 1'b1;
    hold(LvIdle, 100);
    check("t6_no_strobe", evq.size(), 32'd0);
    send_word(1'b0, 16'h5555, 1'b1, 16, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b0, 16'h5555, 1'b1);
    expect_event("t6_next", exp, 1'b1, c1);

    // Bit-rate offsets
    send_word(1'b0, 16'hFFFF, 1'b1, 17, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b0, 16'hFFFF, 1'b1);
    expect_event("t5_slow", exp, 1'b1, c1);
    send_word(1'b0, 16'h0000, 1'b1, 15, 17, -1);
    hold(LvIdle, 60);
    exp = model(1'b0, 16'h0000, 1'b1);
    expect_event("t5_fast", exp, 1'b1, c1);

    // Receiver disabled mid-word: dropped without strobes
    fork
      send_word(1'b0, 16'h3C3C, 1'b1, 16, 17, -1);
      begin
        repeat (400) @(negedge clk);
        rx_en = 1'b0;
      end
    join
    hold(LvIdle, 100);
    check("t7_no_strobe", evq.size(), 32'd0);
    check("t7_busy", {31'b0, rx_busy}, 32'd0);
    check("t7_data_held", {16'b0, rx_data}, 32'h0000);
    rx_en = 1'b1;
    hold(LvIdle, 20);

    // Randomised words at nominal and offset rates
    for (int k = 0; k < 12; k++) begin
      bit          cmd;
      bit          par;
      logic [15:0] data;
      int          h;
      cmd  = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      par  = ~(^data);
      if ($urandom_range(0, 3) == 0) par = ~par;
      h    = 15 + $urandom_range(0, 2);
      send_word(cmd, data, par, h, 17, -1);
      hold(LvIdle, $urandom_range(40, 200));
      exp = model(cmd, data, par);
      expect_event($sformatf("rnd%0d", k), exp, 1'b1, c1);
    end
    check("final_no_extra", evq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mkio_manchester_rx.md
Name: mkio_manchester_rx

Overview:
Manchester-II receive decoder for one MKIO (MIL-STD-1553B) channel, at 1 Mbit/s.
- Takes the differential bus receiver outputs DI1/DI0 and recovers sync type, 16 data bits and odd parity.
- Presents each decoded word to the MKIO protocol core as a one-cycle strobe.
- One instance per channel (A, B), directly upstream of the protocol/RT state machine.

Parameters:
CLK_PER_HALFBIT, 16, clk cycles per Manchester half-bit (32 MHz clock, 500 ns half-bit).
SYNC_MIN, 44, minimum first-half sync run length accepted (clk cycles).
SYNC_MAX, 68, maximum first-half sync run length accepted (allows merge with previous parity half-bit).
RESYNC_WIN, 4, ± window around mid-bit in which a transition re-centres the bit counter.

Ports:
clk  input  1  system clock, 32 MHz
reset  input  1  asynchronous, active-low reset
rx_en  input  1  receiver enable; low forces IDLE
DI1  input  1  bus receiver positive output
DI0  input  1  bus receiver negative output
rx_data  output  16  decoded word, MSB = first bit on bus
rx_cmd_sync  output  1  1 = command/status sync (+ then −), 0 = data sync
rx_valid  output  1  one-cycle strobe, good word in rx_data/rx_cmd_sync
rx_err  output  1  one-cycle strobe, word aborted
rx_err_code  output  2  01 sync, 10 Manchester, 11 parity; valid with rx_err
rx_busy  output  1  high from sync acceptance until word end

Behaviour:
- Reset (async, reset=0): all outputs 0, synchroniser flops 0, state IDLE, counters 0. Reset mid-word discards the partial word and emits no strobe.
- Input path: DI1/DI0 each pass through a 2-FF synchroniser. Line level: +1 = (1,0), −1 = (0,1), invalid = equal.
- Run counter: counts consecutive cycles of an unchanged valid level, saturating at SYNC_MAX+1. Cleared on any level change or invalid level.
- IDLE (rx_en=1):
  - On a +1→−1 or −1→+1 change with previous run length in [SYNC_MIN, SYNC_MAX], accept the sync.
  - cmd_sync = (previous level == +1).
  - Go to SYNC2; bit counter cnt = 0; rx_busy = 1.
  - Runs outside the window, or invalid levels, are ignored silently.
- SYNC2:
  - At cnt = 24, level must equal the post-transition level; otherwise rx_err, code 01, go to IDLE.
  - At cnt = 47, go to DATA with bit index 0 and cnt = 0.
- DATA (17 bits: data[15:0] MSB first, then parity), cnt 0..31 per bit:
  - Sample h1 at cnt = 8 and h2 at cnt = 24.
  - If h1 or h2 is invalid, or h1 == h2: rx_err, code 10, go to IDLE.
  - Bit value = (h1 == +1).
  - Resync: a level change seen at cnt in [16−RESYNC_WIN, 16+RESYNC_WIN] loads cnt = 16 on the next cycle.
  - At cnt = 31, advance the bit index.
- Word end: in the cycle after the parity h2 sample, check that data plus parity hold an odd count of ones.
  - Pass: rx_valid = 1 for one cycle.
  - Fail: rx_err = 1 with code 11.
  - Either case: rx_data and rx_cmd_sync are loaded; rx_busy drops; go to IDLE.
  - The run counter keeps running across word end, so a back-to-back sync (no gap) is detected.
- Latency: rx_valid is 27 clk cycles after the DI edge that starts the parity bit (2 synchroniser + 24 + 1).
- rx_data/rx_cmd_sync hold their value until the next word end; they are not cleared on an error.
- rx_en = 0: immediate return to IDLE, no strobes. A word in progress is dropped without rx_err.
- rx_valid and rx_err are never high in the same cycle.

Test Plan:
- Command sync, data 0x0867 (RT 1, receive, SA 3, WC 7), parity 1 → one rx_valid, rx_data = 0x0867, rx_cmd_sync = 1, rx_err never asserted.
- Data sync 0xA5A5 (parity 1) immediately followed, no gap, by data sync 0x0001 (parity 0) → two rx_valid pulses 640 cycles apart, rx_cmd_sync = 0, data 0xA5A5 then 0x0001.
- Command 0x0867 sent with parity 0 → rx_err with code 11, rx_data = 0x0867, no rx_valid.
- Data 0x1234 with both halves of bit 5 forced +1 → rx_err with code 10, rx_busy drops. A following data word 0x00FF (parity 1) decodes correctly.
- Transmit with half-bit = 17 cycles (bit-rate offset) for data 0xFFFF (parity 1), and 15 cycles for 0x0000 (parity 1) → both decode as valid via resync.
- Assert reset low at bit 8 of a command word → all outputs 0 while low. After release, the next data word 0x5555 (parity 1) yields rx_valid with 0x5555.
